// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control unit.
// One shared datapath is sequenced through fetch, decode, execute, memory and
// write-back states. Memory states stall on MemRdy, with an optional watchdog
// that drops the access after TIMEOUT stalled cycles. Retired instructions are
// counted in RetCnt.
module mips_mc_control #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemRdy,
  output logic             MemReq,
  output logic             MemWr,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCEn,
  output logic [1:0]       PCSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic             RegWE,
  output logic [1:0]       RegDst,
  output logic [1:0]       MemToReg,
  output logic             Illegal,
  output logic             Fault,
  output logic [CNT_W-1:0] RetCnt
);

  localparam int TMO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RTWB, S_IEXEC, S_IWB, S_BRANCH, S_JUMP, S_JAL
  } state_e;

  state_e           state_q, state_d, dec_state;
  logic             run_q;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] ret_q;
  logic             op_illegal;
  logic             wait_st, stall, tmo_hit, retire;

  // Funct is consumed by the ALU decoder, not by the sequencer.
  logic unused_funct;
  assign unused_funct = ^Funct;

  // run_q holds the FSM idle (and all outputs low) until the first edge after reset release.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      tmo_q   <= '0;
      ret_q   <= '0;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      tmo_q   <= tmo_d;
      if (retire) ret_q <= ret_q + 1'b1;
    end
  end

  // Map the latched opcode to its first execute state; unknown opcodes go back to fetch.
  always_comb begin
    dec_state  = S_FETCH;
    op_illegal = 1'b0;
    case (Op)
      OP_LW, OP_SW:                                  dec_state = S_MEMADR;
      OP_RTYPE:                                      dec_state = S_EXEC;
      OP_BEQ, OP_BNE:                                dec_state = S_BRANCH;
      OP_J:                                          dec_state = S_JUMP;
      OP_JAL:                                        dec_state = S_JAL;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI:    dec_state = S_IEXEC;
      default:                                       op_illegal = 1'b1;
    endcase
  end

  // Memory watchdog: counts stalled cycles; a ready on the deadline cycle still wins.
  always_comb begin
    wait_st = run_q && (state_q inside {S_FETCH, S_MEMRD, S_MEMWR});
    stall   = wait_st && !MemRdy;
    tmo_hit = (TIMEOUT != 0) && stall && (tmo_q == TMO_MAX);
    tmo_d   = '0;
    if ((TIMEOUT != 0) && stall && !tmo_hit) tmo_d = tmo_q + 1'b1;
  end

  // Next state and retirement (retire marks the edge leaving a completing state).
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    if (run_q) begin
      case (state_q)
        S_FETCH:  if (MemRdy) state_d = S_DECODE;
        S_DECODE: state_d = dec_state;
        S_MEMADR: state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (MemRdy)       state_d = S_MEMWB;
          else if (tmo_hit) state_d = S_FETCH;
        end
        S_MEMWR: begin
          if (MemRdy) begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end else if (tmo_hit) begin
            state_d = S_FETCH;
          end
        end
        S_EXEC:   state_d = S_RTWB;
        S_IEXEC:  state_d = S_IWB;
        S_MEMWB, S_RTWB, S_IWB, S_BRANCH, S_JUMP, S_JAL: begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Per-state datapath controls; PCEn additionally follows MemRdy in fetch and Zero in branch.
  always_comb begin
    MemReq   = 1'b0;
    MemWr    = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    PCEn     = 1'b0;
    PCSrc    = 2'b00;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    RegWE    = 1'b0;
    RegDst   = 2'b00;
    MemToReg = 2'b00;
    Illegal  = 1'b0;
    Fault    = tmo_hit;
    if (run_q) begin
      case (state_q)
        S_FETCH: begin
          MemReq  = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = MemRdy;
          PCEn    = MemRdy;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          Illegal = op_illegal;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          MemReq = 1'b1;
          IorD   = 1'b1;
        end
        S_MEMWB: begin
          RegWE    = 1'b1;
          MemToReg = 2'b01;
        end
        S_MEMWR: begin
          MemReq = 1'b1;
          MemWr  = 1'b1;
          IorD   = 1'b1;
        end
        S_EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RTWB: begin
          RegWE  = 1'b1;
          RegDst = 2'b01;
        end
        S_IEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        S_IWB: RegWE = 1'b1;
        S_BRANCH: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b01;
          PCSrc   = 2'b01;
          PCEn    = (Op == OP_BEQ) ? Zero : !Zero;
        end
        S_JUMP: begin
          PCSrc = 2'b10;
          PCEn  = 1'b1;
        end
        S_JAL: begin
          RegWE    = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 2'b10;
          PCSrc    = 2'b10;
          PCEn     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign RetCnt = ret_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Testbench for mips_mc_control: directed vector table, hand-written reset and
// watchdog sequences, and randomized instruction streams checked against a
// per-opcode step-plan model.
module tb_mips_mc_control;

  localparam int TMO = 4;

  logic       CLK, RST, Zero, MemRdy;
  logic [5:0] Op, Funct;
  logic       MemReq, MemWr, IorD, IRWrite, PCEn, ALUSrcA, RegWE, Illegal, Fault;
  logic [1:0] PCSrc, ALUSrcB, ALUOp, RegDst, MemToReg;
  logic [7:0] RetCnt;

  mips_mc_control #(.CNT_W(8), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .Op(Op), .Funct(Funct), .Zero(Zero), .MemRdy(MemRdy),
    .MemReq(MemReq), .MemWr(MemWr), .IorD(IorD), .IRWrite(IRWrite), .PCEn(PCEn),
    .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .RegWE(RegWE), .RegDst(RegDst), .MemToReg(MemToReg), .Illegal(Illegal),
    .Fault(Fault), .RetCnt(RetCnt)
  );

  typedef struct packed {
    logic       mreq, mwr, iord, irw, pcen;
    logic [1:0] pcsrc;
    logic       asa;
    logic [1:0] asb, aluop;
    logic       rwe;
    logic [1:0] rdst, m2r;
    logic       ill, flt;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       rdy;
    ctl_t       exp;
    logic [7:0] ret;
  } vec_t;

  ctl_t act_c;
  assign act_c = {MemReq, MemWr, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
                  RegWE, RegDst, MemToReg, Illegal, Fault};

  int         nvec = 0;
  int         nfail = 0;
  logic [7:0] ret_m = 8'd0;
  vec_t       tbl[$];
  ctl_t       cZ, cF1, cF0, cFf, cD, cDi, cA, cR, cM, cW, cE, cX, cB1, cB0, cJ, cL;

  logic [5:0] legal_ops [12] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                 6'b000101, 6'b000010, 6'b000011, 6'b001000,
                                 6'b001010, 6'b001100, 6'b001101, 6'b001110};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Argument order: MemReq MemWr IorD IRWrite PCEn PCSrc ALUSrcA ALUSrcB ALUOp RegWE RegDst MemToReg Illegal Fault
  function automatic ctl_t ev(int mrq, int mwr, int iord, int irw, int pcen, int pcs,
                              int asa, int asb, int aop, int rwe, int rdst, int m2r,
                              int ill, int flt);
    return {1'(mrq), 1'(mwr), 1'(iord), 1'(irw), 1'(pcen), 2'(pcs), 1'(asa), 2'(asb),
            2'(aop), 1'(rwe), 2'(rdst), 2'(m2r), 1'(ill), 1'(flt)};
  endfunction

  // Sequence of steps an instruction walks through; F/R/W wait on memory.
  function automatic string plan(logic [5:0] op);
    case (op)
      6'b100011: return "FDARM";
      6'b101011: return "FDAW";
      6'b000000: return "FDEX";
      6'b000100, 6'b000101: return "FDB";
      6'b000010: return "FDJ";
      6'b000011: return "FDL";
      6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110: return "FDIY";
      default: return "FD";
    endcase
  endfunction

  function automatic ctl_t model_ctl(byte kind, logic [5:0] op, logic z, logic rdy,
                                     logic flt, logic ill);
    int r  = rdy ? 1 : 0;
    int f  = flt ? 1 : 0;
    int il = ill ? 1 : 0;
    int pc = (op == 6'b000100) ? (z ? 1 : 0) : (z ? 0 : 1);
    case (kind)
      "F": return ev(1, 0, 0, r, r, 0, 0, 1, 0, 0, 0, 0, 0, f);
      "D": return ev(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, il, 0);
      "A": return ev(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
      "R": return ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f);
      "W": return ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, f);
      "M": return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
      "E": return ev(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
      "X": return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      "I": return ev(0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0);
      "Y": return ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      "B": return ev(0, 0, 0, 0, pc, 1, 1, 0, 1, 0, 0, 0, 0, 0);
      "J": return ev(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      "L": return ev(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 2, 0, 0);
      default: return '0;
    endcase
  endfunction

  task automatic check(string name, ctl_t exp, logic [7:0] eret);
    nvec++;
    if (act_c !== exp || RetCnt !== eret) begin
      nfail++;
      $display("FAIL %s: got ctl=%b RetCnt=%0d, expected ctl=%b RetCnt=%0d",
               name, act_c, RetCnt, exp, eret);
    end
  endtask

  // Drive at posedge+1, compare at negedge, return at the next posedge+1.
  task automatic apply(logic [5:0] op, logic [5:0] fn, logic z, logic rdy, ctl_t exp,
                       logic [7:0] eret, string name);
    Op = op; Funct = fn; Zero = z; MemRdy = rdy;
    @(negedge CLK);
    check(name, exp, eret);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0; MemRdy = 1'b1; Op = 6'd0; Funct = 6'd0; Zero = 1'b0;
    @(negedge CLK);
    check("rst_hold", cZ, 8'd0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("rst_release", cZ, 8'd0);
    @(posedge CLK);
    #1;
    ret_m = 8'd0;
  endtask

  task automatic run_instr(logic [5:0] op, int pct);
    string p;
    int    k, stalls;
    byte   kind;
    logic  ill, mem, rdy, z, flt;
    p = plan(op);
    k = 0;
    stalls = 0;
    ill = (p.len() == 2);
    while (k < p.len()) begin
      kind = p[k];
      mem  = (kind == "F") || (kind == "R") || (kind == "W");
      rdy  = ($urandom_range(0, 99) < pct);
      z    = 1'($urandom);
      flt  = mem && !rdy && (stalls == TMO);
      apply(op, 6'($urandom), z, rdy, model_ctl(kind, op, z, rdy, flt, ill), ret_m,
            $sformatf("rand op=%b step=%c", op, kind));
      if (flt) return;
      if (mem && !rdy) stalls++;
      else begin
        stalls = 0;
        k++;
      end
    end
    if (!ill) ret_m++;
  endtask

  initial begin
    cZ  = '0;
    cF1 = ev(1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cF0 = ev(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    cFf = ev(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    cD  = ev(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    cDi = ev(0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 0, 1, 0);
    cA  = ev(0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0);
    cR  = ev(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cM  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    cW  = ev(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cE  = ev(0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    cX  = ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cB1 = ev(0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cB0 = ev(0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    cJ  = ev(0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    cL  = ev(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 2, 2, 0, 0);

    // add
    tbl.push_back('{6'b000000, 6'h20, 1'b0, 1'b1, cF1, 8'd0});
    tbl.push_back('{6'b000000, 6'h20, 1'b0, 1'b0, cD,  8'd0});
    tbl.push_back('{6'b000000, 6'h20, 1'b1, 1'b0, cE,  8'd0});
    tbl.push_back('{6'b000000, 6'h20, 1'b0, 1'b1, cX,  8'd0});
    // lw with three stalled cycles in MEMRD
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b1, cF1, 8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b1, cD,  8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b0, cA,  8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b0, cR,  8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b0, cR,  8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b0, cR,  8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b1, cR,  8'd1});
    tbl.push_back('{6'b100011, 6'h00, 1'b0, 1'b0, cM,  8'd1});
    // beq taken, bne not taken
    tbl.push_back('{6'b000100, 6'h00, 1'b1, 1'b1, cF1, 8'd2});
    tbl.push_back('{6'b000100, 6'h00, 1'b1, 1'b1, cD,  8'd2});
    tbl.push_back('{6'b000100, 6'h00, 1'b1, 1'b0, cB1, 8'd2});
    tbl.push_back('{6'b000101, 6'h00, 1'b1, 1'b1, cF1, 8'd3});
    tbl.push_back('{6'b000101, 6'h00, 1'b1, 1'b1, cD,  8'd3});
    tbl.push_back('{6'b000101, 6'h00, 1'b1, 1'b1, cB0, 8'd3});
    // jal
    tbl.push_back('{6'b000011, 6'h00, 1'b0, 1'b1, cF1, 8'd4});
    tbl.push_back('{6'b000011, 6'h00, 1'b0, 1'b1, cD,  8'd4});
    tbl.push_back('{6'b000011, 6'h00, 1'b0, 1'b0, cL,  8'd4});
    // unsupported opcode: pulses Illegal, back to fetch, not retired
    tbl.push_back('{6'b111111, 6'h00, 1'b0, 1'b1, cF1, 8'd5});
    tbl.push_back('{6'b111111, 6'h00, 1'b0, 1'b1, cDi, 8'd5});
    tbl.push_back('{6'b111111, 6'h00, 1'b0, 1'b0, cF0, 8'd5});

    RST = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemRdy = 1'b0;
    @(posedge CLK);
    #1;
    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      apply(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rdy, tbl[i].exp, tbl[i].ret,
            $sformatf("tbl[%0d]", i));

    // Fetch watchdog: Fault on the cycle after TMO stalls, then fetch retries.
    do_reset();
    for (int i = 0; i < TMO; i++) apply(6'd0, 6'd0, 1'b0, 1'b0, cF0, 8'd0, "fetch_stall");
    apply(6'd0, 6'd0, 1'b0, 1'b0, cFf, 8'd0, "fetch_fault");
    apply(6'd0, 6'd0, 1'b0, 1'b0, cF0, 8'd0, "fetch_retry");

    // Ready on the deadline cycle completes normally; then reset aborts a store.
    do_reset();
    for (int i = 0; i < TMO; i++) apply(6'b000010, 6'd0, 1'b0, 1'b0, cF0, 8'd0, "late_stall");
    apply(6'b000010, 6'd0, 1'b0, 1'b1, cF1, 8'd0, "late_rdy_fetch");
    apply(6'b000010, 6'd0, 1'b0, 1'b0, cD,  8'd0, "late_rdy_decode");
    apply(6'b000010, 6'd0, 1'b0, 1'b0, cJ,  8'd0, "jump");
    apply(6'b101011, 6'd0, 1'b0, 1'b1, cF1, 8'd1, "sw_fetch");
    apply(6'b101011, 6'd0, 1'b0, 1'b1, cD,  8'd1, "sw_decode");
    apply(6'b101011, 6'd0, 1'b0, 1'b1, cA,  8'd1, "sw_memadr");
    MemRdy = 1'b0;
    #1;
    check("sw_memwr", cW, 8'd1);
    RST = 1'b0;
    #1;
    check("rst_abort", cZ, 8'd0);
    @(posedge CLK);
    #1;
    do_reset();

    // Random instruction stream; counter is 8 bits so it wraps.
    for (int n = 0; n < 400; n++) begin
      int         sel;
      int         pct;
      logic [5:0] op;
      sel = $urandom_range(0, 2);
      pct = (sel == 0) ? 90 : ((sel == 1) ? 50 : 20);
      if ($urandom_range(0, 4) == 0) op = 6'($urandom);
      else op = legal_ops[$urandom_range(0, 11)];
      run_instr(op, pct);
    end
    apply(6'd0, 6'd0, 1'b0, 1'b0, cF0, ret_m, "final_fetch");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle control FSM for the MIPS datapath: fetch/decode/register file/ALU/memory/PC are shared across cycles instead of duplicated.
- Decodes Op/Funct from the latched instruction register (IR) and drives per-cycle datapath selects and enables, including the register-file write enable and write-address select.
- Stalls on a memory ready handshake.
- Counts retired instructions.

Parameters:
- CNT_W, 32, width of retired-instruction counter.
- TIMEOUT, 255, max cycles waiting on MemRdy before Fault pulse (0 = disabled).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  asynchronous active-low reset.
- Op  input  6  IR[31:26] from instruction register.
- Funct  input  6  IR[5:0].
- Zero  input  1  ALU zero flag, valid in BRANCH state.
- MemRdy  input  1  memory access completes this cycle.
- MemReq  output  1  memory access request.
- MemWr  output  1  1 = write, 0 = read; valid when MemReq=1.
- IorD  output  1  0 = address from PC, 1 = from ALUOut.
- IRWrite  output  1  load IR.
- PCEn  output  1  load PC.
- PCSrc  output  2  00 ALU result, 01 ALUOut (branch target), 10 jump target {PC[31:28], IR[25:0], 2'b00}.
- ALUSrcA  output  1  0 = PC, 1 = Rdata1.
- ALUSrcB  output  2  00 Rdata2, 01 constant 4, 10 Ed32, 11 Ed32<<2.
- ALUOp  output  2  00 add, 01 sub, 10 per Funct, 11 per Op (immediate).
- RegWE  output  1  register-file write enable.
- RegDst  output  2  00 IR[20:16], 01 IR[15:11], 10 register 31.
- MemToReg  output  2  00 ALUOut, 01 memory data register (MDR), 10 PC (link).
- Illegal  output  1  one-cycle pulse on an unsupported opcode.
- Fault  output  1  one-cycle pulse on MemRdy timeout.
- RetCnt  output  CNT_W  retired-instruction count.

Behaviour:
- RST=0: state=FETCH, RetCnt=0, timeout counter=0, all outputs 0.
  - FETCH outputs are asserted only from the first clock edge after RST rises.
  - RST asserted mid-instruction aborts the instruction immediately; no partial write.
- All outputs are Moore-decoded from state, except PCEn in FETCH and BRANCH, as listed below.
- Unlisted outputs are 0 in every state.

FSM states:
- FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCEn=MemRdy.
  - MemRdy=1 -> DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precompute branch target into ALUOut). Next state by Op:
  - lw 100011 / sw 101011 -> MEMADR
  - 000000 -> EXEC
  - beq 000100 / bne 000101 -> BRANCH
  - j 000010 -> JUMP
  - jal 000011 -> JAL
  - addi 001000, slti 001010, andi 001100, ori 001101, xori 001110 -> IEXEC
  - any other Op -> FETCH with Illegal=1; not retired.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
- MEMRD: MemReq=1, MemWr=0, IorD=1. MemRdy -> MEMWB.
- MEMWB: RegWE=1, RegDst=00, MemToReg=01 -> FETCH, retire.
- MEMWR: MemReq=1, MemWr=1, IorD=1. MemRdy -> FETCH, retire.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RTWB.
- RTWB: RegWE=1, RegDst=01, MemToReg=00 -> FETCH, retire.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> IWB.
- IWB: RegWE=1, RegDst=00, MemToReg=00 -> FETCH, retire.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01.
  - PCEn=Zero for beq, PCEn=~Zero for bne.
  - -> FETCH, retire.
- JUMP: PCSrc=10, PCEn=1 -> FETCH, retire.
- JAL: RegWE=1, RegDst=10, MemToReg=10, PCSrc=10, PCEn=1 -> FETCH, retire.
  - PC still holds PC+4 during JAL, so the link value is correct.

Counters:
- Retire: RetCnt+1 on the edge leaving a retiring state; wraps modulo 2^CNT_W.
- Timeout: counts cycles spent in FETCH/MEMRD/MEMWR with MemRdy=0; cleared on MemRdy=1 or state change.
  - At TIMEOUT: Fault=1 for one cycle, state -> FETCH, counter cleared, instruction dropped (not retired).
  - In FETCH, PC is not advanced and fetch retries.
  - MemRdy=1 in the same cycle the count reaches TIMEOUT: the access completes normally, no Fault.
- RegWE never asserts in any state other than MEMWB, RTWB, IWB, JAL.

Cycle counts (MemRdy=1):
- lw = 5
- sw = 4
- R-type / immediate = 4
- branch / j / jal = 3

Test Plan:
- Reset then add (Op=0, Funct=100000), MemRdy=1 -> states FETCH, DECODE, EXEC, RTWB; RegWE=1, RegDst=01 in cycle 4 only; RetCnt=1.
- lw with MemRdy held 0 for 3 cycles in MEMRD -> MemReq=1, IorD=1 held; RegWE=1, MemToReg=01 in MEMWB; total 8 cycles; RetCnt+1.
- beq Zero=1 -> PCEn=1, PCSrc=01 in BRANCH. bne Zero=1 -> PCEn=0. Both retire.
- jal -> JAL state: RegWE=1, RegDst=10, MemToReg=10, PCEn=1, PCSrc=10; 3 cycles.
- Op=111111 -> Illegal pulses in DECODE, next state FETCH, RetCnt unchanged, RegWE never 1.
- TIMEOUT=4, MemRdy=0 in FETCH -> Fault after 4 stall cycles, IRWrite/PCEn never 1. RST low during MEMWR -> all outputs 0 immediately, RetCnt=0.
